// File: rtl/l2_port_arbiter.sv
// ----------------------------------------------------------------------------
// l2_port_arbiter
//
// Shares the single L2 line port between the instruction cache and the data
// cache. Each L1 posts a line-fill (or, for the D side, a write-back) request
// and holds it until granted. Only one L2 transaction is in flight at a time.
// When both sides request together, the side that was not served last wins,
// so the two caches alternate.
//
// Transaction sequence: IDLE -> XFER -> DONE -> IDLE.
//   IDLE : a pending request is granted (1-cycle gnt pulse) and the L2
//          request is launched with a line-aligned address.
//   XFER : the L2 request is held stable until l2_ack; read data is captured
//          into the owner's fill register.
//   DONE : the owner's done pulse is shown and the fairness pointer updated.
//
// Ports
//   clk, clear              clock (rising edge), async active-high reset
//   i_req, i_add            I-cache fill request and miss address
//   i_gnt, i_done, i_data   I-side grant pulse, completion pulse, fill line
//   d_req, d_we, d_add,     D-cache request, write-back flag, address and
//   d_wdata                 write-back line
//   d_gnt, d_done, d_data   D-side grant pulse, completion pulse, fill line
//   l2_req, l2_we, l2_add,  L2 request (held until ack), write enable,
//   l2_wdata                line-aligned address, write line
//   l2_ack, l2_rdata        L2 completion and read line (same cycle)
//   busy                    high whenever a transaction is under way
//
// Optional build macro
//   L2_ARB_STATS_EN : adds saturating 32-bit counters i_txns, d_txns and
//                     conflicts as extra outputs, cleared by clear.
// ----------------------------------------------------------------------------
module l2_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 512,
    parameter int unsigned OFF_W  = 6
) (
    input  logic              clk,
    input  logic              clear,
    // I-cache side
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_add,
    output logic              i_gnt,
    output logic              i_done,
    output logic [LINE_W-1:0] i_data,
    // D-cache side
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_add,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [LINE_W-1:0] d_data,
    // L2 side
    output logic              l2_req,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_add,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic              l2_ack,
    input  logic [LINE_W-1:0] l2_rdata,
    // status
    output logic              busy
`ifdef L2_ARB_STATS_EN
    ,
    output logic [31:0]       i_txns,
    output logic [31:0]       d_txns,
    output logic [31:0]       conflicts
`endif
);

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    state_e state_q, state_d;

    // Owner / fairness encoding: 0 = I-cache, 1 = D-cache.
    logic owner_q;
    logic last_q;

    logic              i_gnt_q, d_gnt_q;
    logic              i_done_q, d_done_q;
    logic [LINE_W-1:0] i_data_q, d_data_q;
    logic              l2_req_q, l2_we_q;
    logic [ADDR_W-1:0] l2_add_q;
    logic [LINE_W-1:0] l2_wdata_q;

    // Decoded per-state events.
    logic              any_req;
    logic              pick_d;
    logic              grant_now;
    logic              ack_now;
    logic              done_now;
    logic [ADDR_W-1:0] sel_add;
    logic [ADDR_W-1:0] aligned_add;

    // ------------------------------------------------------------------
    // Arbitration and request steering
    // ------------------------------------------------------------------
    always_comb begin
        any_req   = i_req | d_req;
        // D wins when it is alone, or when both request and I went last.
        pick_d    = d_req & (~i_req | ~last_q);
        grant_now = (state_q == StIdle) & any_req;
        ack_now   = (state_q == StXfer) & l2_ack;
        done_now  = (state_q == StDone);

        sel_add                  = pick_d ? d_add : i_add;
        aligned_add              = sel_add;
        aligned_add[OFF_W-1:0]   = '0;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StXfer;
            StXfer:  if (l2_ack)  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction datapath: grant/done pulses, L2 request, fill lines
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            owner_q    <= 1'b0;
            last_q     <= 1'b0;
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            i_data_q   <= '0;
            d_data_q   <= '0;
            l2_req_q   <= 1'b0;
            l2_we_q    <= 1'b0;
            l2_add_q   <= '0;
            l2_wdata_q <= '0;
        end else begin
            // Pulses last exactly one cycle.
            i_gnt_q  <= 1'b0;
            d_gnt_q  <= 1'b0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;

            if (grant_now) begin
                owner_q    <= pick_d;
                i_gnt_q    <= ~pick_d;
                d_gnt_q    <= pick_d;
                l2_req_q   <= 1'b1;
                l2_we_q    <= pick_d & d_we;
                l2_add_q   <= aligned_add;
                l2_wdata_q <= pick_d ? d_wdata : '0;
            end

            if (ack_now) begin
                l2_req_q <= 1'b0;
                if (owner_q) begin
                    d_done_q <= 1'b1;
                    // Write-backs leave the last D fill line untouched.
                    if (!l2_we_q) begin
                        d_data_q <= l2_rdata;
                    end
                end else begin
                    i_done_q <= 1'b1;
                    i_data_q <= l2_rdata;
                end
            end

            if (done_now) begin
                last_q <= owner_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy     = (state_q != StIdle);
        i_gnt    = i_gnt_q;
        d_gnt    = d_gnt_q;
        i_done   = i_done_q;
        d_done   = d_done_q;
        i_data   = i_data_q;
        d_data   = d_data_q;
        l2_req   = l2_req_q;
        l2_we    = l2_we_q;
        l2_add   = l2_add_q;
        l2_wdata = l2_wdata_q;
    end

`ifdef L2_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating activity counters
    // ------------------------------------------------------------------
    logic [31:0] i_txns_q, d_txns_q, conflicts_q;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            i_txns_q    <= '0;
            d_txns_q    <= '0;
            conflicts_q <= '0;
        end else begin
            // Counted on the edge that raises the matching done pulse.
            if (ack_now && !owner_q && (i_txns_q != 32'hFFFF_FFFF)) begin
                i_txns_q <= i_txns_q + 32'd1;
            end
            if (ack_now && owner_q && (d_txns_q != 32'hFFFF_FFFF)) begin
                d_txns_q <= d_txns_q + 32'd1;
            end
            if (grant_now && i_req && d_req && (conflicts_q != 32'hFFFF_FFFF)) begin
                conflicts_q <= conflicts_q + 32'd1;
            end
        end
    end

    always_comb begin
        i_txns    = i_txns_q;
        d_txns    = d_txns_q;
        conflicts = conflicts_q;
    end
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
module tb_l2_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 512;
    localparam int OFF_W  = 6;

    logic              clk = 1'b0;
    logic              clear;
    logic              i_req, d_req, d_we;
    logic [ADDR_W-1:0] i_add, d_add;
    logic [LINE_W-1:0] d_wdata, rdata;
    wire               i_gnt, i_done, d_gnt, d_done;
    wire [LINE_W-1:0]  i_data, d_data, l2_wdata;
    wire               l2_req, l2_we, busy;
    wire [ADDR_W-1:0]  l2_add;
    wire               l2_ack;
`ifdef L2_ARB_STATS_EN
    wire [31:0]        i_txns, d_txns, conflicts;
`endif

    // L2 responder: automatic (resp_en) or hand-driven (man_ack).
    logic resp_en, man_ack, auto_ack;
    int   resp_dly, resp_cnt;
    assign l2_ack = resp_en ? auto_ack : man_ack;

    int checks = 0;
    int errors = 0;
    int order[$];

    logic [LINE_W-1:0] pat_a, pat_b, pat_c, pat_d;

    always #5 clk = ~clk;

    l2_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFF_W(OFF_W)) dut (
        .clk      (clk),
        .clear    (clear),
        .i_req    (i_req),
        .i_add    (i_add),
        .i_gnt    (i_gnt),
        .i_done   (i_done),
        .i_data   (i_data),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_add    (d_add),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_done   (d_done),
        .d_data   (d_data),
        .l2_req   (l2_req),
        .l2_we    (l2_we),
        .l2_add   (l2_add),
        .l2_wdata (l2_wdata),
        .l2_ack   (l2_ack),
        .l2_rdata (rdata),
        .busy     (busy)
`ifdef L2_ARB_STATS_EN
        ,
        .i_txns   (i_txns),
        .d_txns   (d_txns),
        .conflicts(conflicts)
`endif
    );

    task automatic chk(input string nm, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one transaction record plus per-side fill lines.
    // Side index 0 = I-cache, 1 = D-cache.
    // ------------------------------------------------------------------
    bit                m_txn;      // waiting for the L2 ack
    bit                m_fin;      // done pulse showing, back to idle next
    int                m_who, m_last;
    logic              m_gnt[2], m_done[2];
    logic [LINE_W-1:0] m_data[2];
    logic              m_we;
    logic [ADDR_W-1:0] m_add;
    logic [LINE_W-1:0] m_wdata;

    function automatic int winner(logic ir, logic dr, int last);
        if (ir && dr) return (last == 0) ? 1 : 0;
        return dr ? 1 : 0;
    endfunction

    function automatic logic [ADDR_W-1:0] line_of(logic [ADDR_W-1:0] a);
        return (a >> OFF_W) << OFF_W;
    endfunction

    always @(posedge clk or posedge clear) begin
        if (clear) begin
            m_txn   <= 1'b0;
            m_fin   <= 1'b0;
            m_who   <= 0;
            m_last  <= 0;
            m_gnt   <= '{1'b0, 1'b0};
            m_done  <= '{1'b0, 1'b0};
            m_data  <= '{'0, '0};
            m_we    <= 1'b0;
            m_add   <= '0;
            m_wdata <= '0;
        end else begin
            m_gnt  <= '{1'b0, 1'b0};
            m_done <= '{1'b0, 1'b0};
            if (m_fin) begin
                m_fin  <= 1'b0;
                m_last <= m_who;
            end else if (m_txn) begin
                if (l2_ack) begin
                    m_txn         <= 1'b0;
                    m_fin         <= 1'b1;
                    m_done[m_who] <= 1'b1;
                    if (!m_we) m_data[m_who] <= rdata;
                end
            end else if (i_req || d_req) begin
                m_txn <= 1'b1;
                if (winner(i_req, d_req, m_last) == 1) begin
                    m_who    <= 1;
                    m_gnt[1] <= 1'b1;
                    m_we     <= d_we;
                    m_add    <= line_of(d_add);
                    m_wdata  <= d_wdata;
                end else begin
                    m_who    <= 0;
                    m_gnt[0] <= 1'b1;
                    m_we     <= 1'b0;
                    m_add    <= line_of(i_add);
                    m_wdata  <= '0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("busy", busy, m_txn | m_fin);
        chk("i_gnt", i_gnt, m_gnt[0]);
        chk("d_gnt", d_gnt, m_gnt[1]);
        chk("gnt_exclusive", i_gnt & d_gnt, 1'b0);
        chk("i_done", i_done, m_done[0]);
        chk("d_done", d_done, m_done[1]);
        chk("i_data", i_data, m_data[0]);
        chk("d_data", d_data, m_data[1]);
        chk("l2_req", l2_req, m_txn);
        if (m_txn || clear) begin
            chk("l2_we", l2_we, m_we);
            chk("l2_add", l2_add, m_add);
        end
        if ((m_txn && m_we) || clear) chk("l2_wdata", l2_wdata, m_wdata);
    end

    // Automatic L2 responder: acks resp_dly cycles after seeing l2_req.
    always @(posedge clk) begin
        #2;
        auto_ack = 1'b0;
        if (resp_en && l2_req) begin
            if (resp_cnt >= resp_dly) begin
                auto_ack = 1'b1;
                resp_cnt = 0;
            end else begin
                resp_cnt++;
            end
        end else begin
            resp_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drops each request on its grant and waits for n_done done pulses,
    // then one more cycle so the arbiter is back in idle.
    task automatic serve_all(input int n_done);
        int seen = 0;
        for (int c = 0; c < 100 && seen < n_done; c++) begin
            tick();
            if (d_gnt) begin d_req = 1'b0; order.push_back(1); end
            if (i_gnt) begin i_req = 1'b0; order.push_back(0); end
            if (i_done) seen++;
            if (d_done) seen++;
        end
        chk("serve_done_count", seen, n_done);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        pat_a = {16{32'hA5A5_0001}};
        pat_b = {16{32'hB0B0_0002}};
        pat_c = {16{32'hC3C3_0003}};
        pat_d = {16{32'hD4D4_0004}};
        clear = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_add = '0; d_add = '0; d_wdata = '0; rdata = '0;
        resp_en = 1'b0; man_ack = 1'b0; auto_ack = 1'b0;
        resp_dly = 0; resp_cnt = 0;
        repeat (3) @(posedge clk);
        #2 clear = 1'b0;

        // Reset state.
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_l2_req", l2_req, 1'b0);
        chk("rst_i_data", i_data, '0);
        chk("rst_d_data", d_data, '0);

        // I only, hand-driven ack two cycles after the grant.
        i_req = 1'b1; i_add = 32'h0000_1234;            // edge 0
        tick();                                          // edge 1
        chk("t1_i_gnt", i_gnt, 1'b1);
        chk("t1_l2_req", l2_req, 1'b1);
        chk("t1_l2_add", l2_add, 32'h0000_1200);
        chk("t1_l2_we", l2_we, 1'b0);
        i_req = 1'b0;
        tick();                                          // edge 2
        tick();                                          // edge 3
        chk("t1_no_early_done", i_done, 1'b0);
        rdata = pat_a; man_ack = 1'b1;
        tick();                                          // edge 4
        man_ack = 1'b0;
        chk("t1_i_done", i_done, 1'b1);
        chk("t1_i_data", i_data, pat_a);
        tick();
        chk("t1_idle", busy, 1'b0);

        // D fill, then D write-back that must not disturb d_data.
        resp_en = 1'b1; resp_dly = 1;
        rdata = pat_c; d_req = 1'b1; d_we = 1'b0; d_add = 32'h0000_4567;
        serve_all(1);
        chk("t2_d_fill", d_data, pat_c);
        rdata = pat_d; d_req = 1'b1; d_we = 1'b1;
        d_add = 32'h8000_007F; d_wdata = pat_b;
        tick();
        chk("t2_d_gnt", d_gnt, 1'b1);
        chk("t2_l2_we", l2_we, 1'b1);
        chk("t2_l2_add", l2_add, 32'h8000_0040);
        chk("t2_l2_wdata", l2_wdata, pat_b);
        d_req = 1'b0;
        serve_all(1);
        chk("t2_d_data_kept", d_data, pat_c);
        d_we = 1'b0;

        // Minimum latency: ack in the cycle XFER is entered.
        resp_dly = 0; rdata = pat_b;
        i_req = 1'b1; i_add = 32'h0000_2040;
        tick();
        chk("t3_i_gnt", i_gnt, 1'b1);
        i_req = 1'b0;
        tick();
        chk("t3_i_done", i_done, 1'b1);
        chk("t3_i_data", i_data, pat_b);
        tick();

        // Three conflicting pairs after reset: D, I alternate.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        order.delete();
        for (int p = 0; p < 3; p++) begin
            rdata = (p == 1) ? pat_a : pat_c;
            i_add = 32'h0000_3000 + 32'(p * 64);
            d_add = 32'h0001_3000 + 32'(p * 64);
            i_req = 1'b1; d_req = 1'b1;
            serve_all(2);
        end
        chk("t4_grant_count", order.size(), 6);
        for (int k = 0; k < 6 && k < order.size(); k++) begin
            chk($sformatf("t4_order%0d", k), order[k], (k % 2 == 0) ? 1 : 0);
        end
`ifdef L2_ARB_STATS_EN
        chk("t4_i_txns", i_txns, 32'd3);
        chk("t4_d_txns", d_txns, 32'd3);
        chk("t4_conflicts", conflicts, 32'd3);
`endif

        // Clear mid-XFER abandons the transaction; stray ack ignored.
        resp_en = 1'b0;
        i_req = 1'b1; i_add = 32'h0000_5000;
        tick();
        i_req = 1'b0;
        tick();
        chk("t5_in_xfer", l2_req, 1'b1);
        clear = 1'b1;
        #1;
        chk("t5_clr_busy", busy, 1'b0);
        chk("t5_clr_l2_req", l2_req, 1'b0);
        chk("t5_clr_i_data", i_data, '0);
        chk("t5_clr_d_data", d_data, '0);
        tick();
        clear = 1'b0; man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("t5_no_done", i_done, 1'b0);
        chk("t5_still_idle", busy, 1'b0);
        tick();
        chk("t5_no_done_late", i_done | d_done, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
